// File: rtl/nano_pkg.sv
// Shared types for the nanoprocessor sequencer: opcodes, ALU function codes and FSM states.
// Width-independent; the sequencer extends opcode constants to its own DATA_W.
package nano_pkg;

  localparam int unsigned OpcodeW = 8;
  localparam int unsigned AluOpW  = 4;

  typedef enum logic [OpcodeW-1:0] {
    OpNop = 8'h00,
    OpLda = 8'h01,
    OpSta = 8'h02,
    OpAdd = 8'h03,
    OpSub = 8'h04,
    OpAnd = 8'h05,
    OpOr  = 8'h06,
    OpXor = 8'h07,
    OpJmp = 8'h08,
    OpJz  = 8'h09,
    OpJc  = 8'h0A,
    OpHlt = 8'h0F
  } opcode_t;

  // AluNone is the idle code, so a NOP-latched sequencer drives alu_op = 0.
  typedef enum logic [AluOpW-1:0] {
    AluNone = 4'd0,
    AluPass = 4'd1,
    AluAdd  = 4'd2,
    AluSub  = 4'd3,
    AluAnd  = 4'd4,
    AluOr   = 4'd5,
    AluXor  = 4'd6
  } alu_op_t;

  typedef enum logic [1:0] {
    StFetchOp  = 2'd0,
    StFetchArg = 2'd1,
    StExec     = 2'd2,
    StHalt     = 2'd3
  } state_t;

endpackage

// File: rtl/nano_sequencer_if.sv
// Sequencer <-> datapath signal bundle. mem_ready exists only when NANO_SEQ_WAIT_EN is defined.
// master = sequencer side, slave = datapath/memory side.
interface nano_sequencer_if
  import nano_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] data_in;
  logic              flag_z;
  logic              flag_c;
`ifdef NANO_SEQ_WAIT_EN
  logic              mem_ready;
`endif
  logic              inc_PC;
  logic              load_PC;
  logic              load_I;
  logic              load_AD;
  logic              load_ACC;
  logic              load_FLAGS;
  logic              sel_AD;
  logic              mem_we;
  alu_op_t           alu_op;
  logic              halted;

  modport master (
    input  data_in,
    input  flag_z,
    input  flag_c,
`ifdef NANO_SEQ_WAIT_EN
    input  mem_ready,
`endif
    output inc_PC,
    output load_PC,
    output load_I,
    output load_AD,
    output load_ACC,
    output load_FLAGS,
    output sel_AD,
    output mem_we,
    output alu_op,
    output halted
  );

  modport slave (
    output data_in,
    output flag_z,
    output flag_c,
`ifdef NANO_SEQ_WAIT_EN
    output mem_ready,
`endif
    input  inc_PC,
    input  load_PC,
    input  load_I,
    input  load_AD,
    input  load_ACC,
    input  load_FLAGS,
    input  sel_AD,
    input  mem_we,
    input  alu_op,
    input  halted
  );

endinterface

// File: rtl/nano_decode.sv
// Combinational opcode decoder: instruction class, jump resolution against the flags, ALU code.
// Any value outside the opcode enum (including nonzero bits above bit 7) is flagged illegal.
module nano_decode
  import nano_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] opcode_i,
  input  logic              flag_z_i,
  input  logic              flag_c_i,
  output logic              is_jump_o,
  output logic              jump_taken_o,
  output logic              is_mem_rd_o,
  output logic              is_store_o,
  output logic              is_halt_o,
  output logic              is_illegal_o,
  output alu_op_t           alu_op_o
);

  always_comb begin
    is_jump_o    = 1'b0;
    jump_taken_o = 1'b0;
    is_mem_rd_o  = 1'b0;
    is_store_o   = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    alu_op_o     = AluNone;
    case (opcode_i)
      DATA_W'(OpNop): ;
      DATA_W'(OpLda): begin
        is_mem_rd_o = 1'b1;
        alu_op_o    = AluPass;
      end
      DATA_W'(OpSta): is_store_o = 1'b1;
      DATA_W'(OpAdd): begin
        is_mem_rd_o = 1'b1;
        alu_op_o    = AluAdd;
      end
      DATA_W'(OpSub): begin
        is_mem_rd_o = 1'b1;
        alu_op_o    = AluSub;
      end
      DATA_W'(OpAnd): begin
        is_mem_rd_o = 1'b1;
        alu_op_o    = AluAnd;
      end
      DATA_W'(OpOr): begin
        is_mem_rd_o = 1'b1;
        alu_op_o    = AluOr;
      end
      DATA_W'(OpXor): begin
        is_mem_rd_o = 1'b1;
        alu_op_o    = AluXor;
      end
      DATA_W'(OpJmp): begin
        is_jump_o    = 1'b1;
        jump_taken_o = 1'b1;
      end
      DATA_W'(OpJz): begin
        is_jump_o    = 1'b1;
        jump_taken_o = flag_z_i;
      end
      DATA_W'(OpJc): begin
        is_jump_o    = 1'b1;
        jump_taken_o = flag_c_i;
      end
      DATA_W'(OpHlt): is_halt_o = 1'b1;
      default:        is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/nano_sequencer.sv
// Nanoprocessor control FSM: FETCH_OP -> FETCH_ARG [-> EXEC], plus a terminal HALT state.
// Define NANO_SEQ_WAIT_EN to add the mem_ready wait-state input on the interface.
module nano_sequencer
  import nano_pkg::*;
#(
  parameter int unsigned DATA_W          = 8,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input logic              clk,
  input logic              reset,
  nano_sequencer_if.master bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic              ready;

  logic    is_jump, jump_taken, is_mem_rd, is_store, is_halt, is_illegal;
  alu_op_t dec_alu_op;

  logic inc_pc, load_pc, load_i, load_ad, load_acc, load_flags, sel_ad, mem_we, halted;

`ifdef NANO_SEQ_WAIT_EN
  assign ready = bus.mem_ready;
`else
  assign ready = 1'b1;
`endif

  nano_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .opcode_i     (op_q),
    .flag_z_i     (bus.flag_z),
    .flag_c_i     (bus.flag_c),
    .is_jump_o    (is_jump),
    .jump_taken_o (jump_taken),
    .is_mem_rd_o  (is_mem_rd),
    .is_store_o   (is_store),
    .is_halt_o    (is_halt),
    .is_illegal_o (is_illegal),
    .alu_op_o     (dec_alu_op)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetchOp;
      op_q    <= DATA_W'(OpNop);
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    inc_pc     = 1'b0;
    load_pc    = 1'b0;
    load_i     = 1'b0;
    load_ad    = 1'b0;
    load_acc   = 1'b0;
    load_flags = 1'b0;
    sel_ad     = 1'b0;
    mem_we     = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      StFetchOp: begin
        if (ready) begin
          load_i  = 1'b1;
          inc_pc  = 1'b1;
          op_d    = bus.data_in;
          state_d = StFetchArg;
        end
      end
      StFetchArg: begin
        if (ready) begin
          load_ad = 1'b1;
          // A taken jump must not also raise inc_PC: the PC would drop the load.
          if (is_jump && jump_taken) begin
            load_pc = 1'b1;
            state_d = StFetchOp;
          end else begin
            inc_pc = 1'b1;
            if (is_halt || (is_illegal && HALT_ON_ILLEGAL)) begin
              state_d = StHalt;
            end else if (is_mem_rd || is_store) begin
              state_d = StExec;
            end else begin
              state_d = StFetchOp;
            end
          end
        end
      end
      StExec: begin
        sel_ad = 1'b1;
        if (ready) begin
          if (is_store) begin
            mem_we = 1'b1;
          end else if (is_mem_rd) begin
            load_acc   = 1'b1;
            load_flags = 1'b1;
          end
          state_d = StFetchOp;
        end
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StFetchOp;
      end
    endcase
  end

  // Reset masks every output combinationally so an aborted instruction leaves no strobe behind.
  assign bus.inc_PC     = inc_pc     & ~reset;
  assign bus.load_PC    = load_pc    & ~reset;
  assign bus.load_I     = load_i     & ~reset;
  assign bus.load_AD    = load_ad    & ~reset;
  assign bus.load_ACC   = load_acc   & ~reset;
  assign bus.load_FLAGS = load_flags & ~reset;
  assign bus.sel_AD     = sel_ad     & ~reset;
  assign bus.mem_we     = mem_we     & ~reset;
  assign bus.halted     = halted     & ~reset;
  assign bus.alu_op     = reset ? AluNone : dec_alu_op;

endmodule

// File: tb/tb_nano_sequencer.sv
// Directed bench for nano_sequencer: two instances (halt-on-illegal and NOP-on-illegal) share
// one stimulus stream; strobe vectors are hand-written per cycle.
module tb_nano_sequencer;
  import nano_pkg::*;

  // Strobe vector order: {inc_PC, load_PC, load_I, load_AD, load_ACC, load_FLAGS, sel_AD,
  // mem_we, halted}
  localparam logic [8:0] SZero   = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] SFop    = 9'b1_0_1_0_0_0_0_0_0;
  localparam logic [8:0] SFarg   = 9'b1_0_0_1_0_0_0_0_0;
  localparam logic [8:0] SJmp    = 9'b0_1_0_1_0_0_0_0_0;
  localparam logic [8:0] SExecRd = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] SExecSt = 9'b0_0_0_0_0_0_1_1_0;
  localparam logic [8:0] SSelOnly = 9'b0_0_0_0_0_0_1_0_0;
  localparam logic [8:0] SHalt   = 9'b0_0_0_0_0_0_0_0_1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       flag_z;
  logic       flag_c;
  logic       mem_ready;
  int         compared = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  nano_sequencer_if #(.DATA_W(8)) bus1 ();
  nano_sequencer_if #(.DATA_W(8)) bus2 ();

  assign bus1.data_in = data_in;
  assign bus1.flag_z  = flag_z;
  assign bus1.flag_c  = flag_c;
  assign bus2.data_in = data_in;
  assign bus2.flag_z  = flag_z;
  assign bus2.flag_c  = flag_c;
`ifdef NANO_SEQ_WAIT_EN
  assign bus1.mem_ready = mem_ready;
  assign bus2.mem_ready = mem_ready;
`endif

  nano_sequencer #(.DATA_W(8), .HALT_ON_ILLEGAL(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  nano_sequencer #(.DATA_W(8), .HALT_ON_ILLEGAL(1'b0)) u_dut_nop (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  logic [8:0] st1, st2;
  assign st1 = {bus1.inc_PC, bus1.load_PC, bus1.load_I, bus1.load_AD, bus1.load_ACC,
                bus1.load_FLAGS, bus1.sel_AD, bus1.mem_we, bus1.halted};
  assign st2 = {bus2.inc_PC, bus2.load_PC, bus2.load_I, bus2.load_AD, bus2.load_ACC,
                bus2.load_FLAGS, bus2.sel_AD, bus2.mem_we, bus2.halted};

  task automatic chk9(input string tag, input logic [8:0] act, input logic [8:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, act, exp);
    end
  endtask

  task automatic chk_alu(input string tag, input logic [3:0] exp);
    compared++;
    assert (bus1.alu_op === exp) else begin
      mismatched++;
      $error("FAIL %s/u1 alu_op: observed %0d expected %0d", tag, bus1.alu_op, exp);
    end
    compared++;
    assert (bus2.alu_op === exp) else begin
      mismatched++;
      $error("FAIL %s/u2 alu_op: observed %0d expected %0d", tag, bus2.alu_op, exp);
    end
  endtask

  // Strobe checks plus the two standing invariants, on both instances.
  task automatic sample(input logic [8:0] e1, input logic [8:0] e2, input string tag);
    chk9({tag, "/u1"}, st1, e1);
    chk9({tag, "/u2"}, st2, e2);
    compared++;
    assert (!(st1[8] && st1[7]) && !(st2[8] && st2[7])) else begin
      mismatched++;
      $error("FAIL %s inc_and_load_PC: observed 1 expected 0", tag);
    end
    compared++;
    assert ((!st1[1] || st1[2]) && (!st2[1] || st2[2])) else begin
      mismatched++;
      $error("FAIL %s we_without_sel: observed 1 expected 0", tag);
    end
  endtask

  // One clock: drive data_in after the edge, sample at the falling edge.
  task automatic cycd(input logic [7:0] d, input logic [8:0] e1, input logic [8:0] e2,
                      input string tag);
    data_in = d;
    @(negedge clk);
    sample(e1, e2, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [7:0] d, input logic [8:0] e, input string tag);
    cycd(d, e, e, tag);
  endtask

  task automatic exec_alu(input logic [3:0] exp_alu, input string tag);
    data_in = 8'h00;
    @(negedge clk);
    sample(SExecRd, SExecRd, tag);
    chk_alu(tag, exp_alu);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  alu_op_t alu_exp [5];

  initial begin
    alu_exp   = '{AluAdd, AluSub, AluAnd, AluOr, AluXor};
    reset     = 1'b1;
    data_in   = 8'h00;
    flag_z    = 1'b0;
    flag_c    = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sample(SZero, SZero, "in_reset");
    chk_alu("in_reset", AluNone);
    reset = 1'b0;

    // LDA 0x10 ; HLT
    cyc(8'h01, SFop, "lda_fop");
    cyc(8'h10, SFarg, "lda_farg");
    exec_alu(AluPass, "lda_exec");
    cyc(8'h0F, SFop, "hlt_fop");
    cyc(8'h00, SFarg, "hlt_farg");
    cyc(8'h00, SHalt, "halted_c6");
    for (int i = 0; i < 3; i++) cyc(8'h01, SHalt, "halt_stays");
    do_reset();

    // JMP 0x40 then the next fetch
    cyc(8'h08, SFop, "jmp_fop");
    cyc(8'h40, SJmp, "jmp_farg");
    // JZ not taken, then taken; carry alone must not take JZ
    cyc(8'h09, SFop, "jz_fop");
    flag_c = 1'b1;
    cyc(8'h20, SFarg, "jz_not_taken");
    flag_c = 1'b0;
    cyc(8'h09, SFop, "jz_fop2");
    flag_z = 1'b1;
    cyc(8'h20, SJmp, "jz_taken");
    // JC not taken with only Z set, then taken
    cyc(8'h0A, SFop, "jc_fop");
    cyc(8'h30, SFarg, "jc_not_taken");
    flag_z = 1'b0;
    flag_c = 1'b1;
    cyc(8'h0A, SFop, "jc_fop2");
    cyc(8'h30, SJmp, "jc_taken");
    flag_c = 1'b0;
    // NOP is two cycles
    cyc(8'h00, SFop, "nop_fop");
    cyc(8'h55, SFarg, "nop_farg");
    // STA 0x80: exactly one mem_we cycle
    cyc(8'h02, SFop, "sta_fop");
    cyc(8'h80, SFarg, "sta_farg");
    cyc(8'h00, SExecSt, "sta_exec");
    cyc(8'h03, SFop, "after_sta_fop");
    cyc(8'h80, SFarg, "add_farg");
    exec_alu(AluAdd, "add_exec");
    // ALU opcodes 0x03..0x07
    for (int k = 0; k < 5; k++) begin
      cyc(8'h03 + 8'(k), SFop, "alu_fop");
      cyc(8'h81, SFarg, "alu_farg");
      exec_alu(alu_exp[k], "alu_exec");
    end

    // Illegal opcode: u1 halts, u2 treats it as NOP
    cyc(8'hEE, SFop, "ill_fop");
    cyc(8'h00, SFarg, "ill_farg");
    cycd(8'h00, SHalt, SFop, "ill_next");
    do_reset();

    // Reset asserted during EXEC of ADD
    cyc(8'h03, SFop, "radd_fop");
    cyc(8'h10, SFarg, "radd_farg");
    #2;
    sample(SExecRd, SExecRd, "radd_exec_pre");
    reset = 1'b1;
    #1;
    sample(SZero, SZero, "radd_rst_same_cycle");
    chk_alu("radd_rst_same_cycle", AluNone);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(8'h00, SFop, "radd_after_fop");
    cyc(8'h00, SFarg, "radd_after_farg");

`ifdef NANO_SEQ_WAIT_EN
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc(8'h01, SZero, "wait_fop_hold");
    mem_ready = 1'b1;
    cyc(8'h01, SFop, "wait_fop_fire");
    cyc(8'h10, SFarg, "wait_farg");
    mem_ready = 1'b0;
    cyc(8'h00, SSelOnly, "wait_exec_hold");
    mem_ready = 1'b1;
    exec_alu(AluPass, "wait_exec_fire");
    cyc(8'h00, SFop, "wait_next_fop");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
